i2c_cmd_sequencer: RTL and testbench
====================================

I2C_CMD_SEQUENCER -- requirements
Module: i2c_cmd_sequencer

Interface
REQ-001 SHALL have parameter WB_ADDR_WIDTH, default 2, Wishbone address width.
REQ-002 SHALL have parameter WB_DATA_WIDTH, default 8, Wishbone data width.
REQ-003 SHALL have parameter IRQ_TIMEOUT, default 65535, maximum cycles to wait for irq_i per I2C command.
REQ-004 SHALL have ports:
- clk_i  in  1  clock; all logic on its rising edge.
- rst_n_i  in  1  reset; asynchronous, active-low.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  sequencer accepts a request.
- req_rnw_i  in  1  1 = read one byte, 0 = write one byte.
- req_bus_i  in  4  target I2C bus id.
- req_addr_i  in  7  I2C slave address.
- req_data_i  in  8  write byte.
- rsp_valid_o  out  1  one-cycle response strobe.
- rsp_data_o  out  8  read byte; 0x00 for writes.
- rsp_status_o  out  2  00 ok, 01 NAK, 10 arbitration lost/ERR, 11 timeout.
- cyc_o, stb_o, we_o  out  1 each  Wishbone master controls.
- adr_o  out  WB_ADDR_WIDTH  register address: 0 CSR, 1 DPR, 2 CMDR.
- dat_o  out  WB_DATA_WIDTH  write data.
- dat_i  in  WB_DATA_WIDTH  read data.
- ack_i  in  1  Wishbone acknowledge.
- irq_i  in  1  controller interrupt (command complete).

Function
REQ-005 SHALL drive each Wishbone access as: cyc_o=stb_o=1 with we_o/adr_o/dat_o held stable until the cycle ack_i=1 is sampled, then cyc_o=stb_o=0 for at least one cycle before the next access.
REQ-006 SHALL capture dat_i on the cycle ack_i=1 for reads.
REQ-007 SHALL assert req_ready_o only in IDLE; handshake completes when req_valid_i and req_ready_o are both 1, latching all req_* fields.
REQ-008 SHALL, on the first request after reset only, write CSR=0xC0 (enable + interrupt enable) before any other access.
REQ-009 SHALL sequence per request: DPR=bus; CMDR=0x06 (set bus); WAIT; CMDR=0x04 (start); WAIT; DPR={addr,rnw}; CMDR=0x01 (write); WAIT; then write: DPR=data, CMDR=0x01, WAIT; read: CMDR=0x03 (read with NAK), WAIT, read DPR into rsp_data_o; then CMDR=0x05 (stop); WAIT; RESPOND.
REQ-010 WAIT SHALL idle bus-quiet until irq_i=1, then read CMDR to clear the interrupt and evaluate status bits: bit7 DON, bit6 NAK, bit5 AL, bit4 ERR.
REQ-011 SHALL on NAK set status 01, skip remaining data phase and issue stop before RESPOND.
REQ-012 SHALL on AL or ERR set status 10 and go directly to RESPOND without stop.
REQ-013 SHALL count cycles in WAIT; on reaching IRQ_TIMEOUT without irq_i set status 11 and go to RESPOND; counter clears on every WAIT entry.
REQ-014 SHALL pulse rsp_valid_o for exactly one cycle in RESPOND, rsp_data_o/rsp_status_o held until the next response, then return to IDLE.
REQ-015 SHALL treat the first detected fault as final: later status bits do not overwrite rsp_status_o.
REQ-016 SHALL ignore req_valid_i while not in IDLE; no queuing.
REQ-017 SHALL ignore irq_i outside WAIT.

Reset
REQ-018 SHALL, while rst_n_i=0, force state IDLE, cyc_o=stb_o=we_o=0, adr_o=0, dat_o=0, req_ready_o=0, rsp_valid_o=0, rsp_data_o=0, rsp_status_o=00, timeout counter=0, enabled flag=0.
REQ-019 SHALL raise req_ready_o the first clock edge after rst_n_i deasserts.
REQ-020 SHALL on reset mid-transaction abandon the Wishbone cycle immediately (cyc_o drops asynchronously) and emit no response; after reset the CSR enable write is repeated.

Verification
REQ-021 First write, bus 0, addr 0x22, data 0x5A, slave ACKs -> Wishbone writes CSR=0xC0, DPR=0x00, CMDR=0x06, CMDR=0x04, DPR=0x44, CMDR=0x01, DPR=0x5A, CMDR=0x01, CMDR=0x05; rsp_status_o=00.
REQ-022 Read, bus 1, addr 0x22, slave returns 0xA5 -> DPR=0x45 written, CMDR=0x03 issued, rsp_data_o=0xA5, status 00, no second CSR write.
REQ-023 Address NAK (CMDR status read 0x40) -> no data-phase access, stop issued, rsp_status_o=01.
REQ-024 irq_i held 0, IRQ_TIMEOUT=16 -> after 16 WAIT cycles rsp_valid_o pulses with status 11.
REQ-025 ack_i delayed 5 cycles on every access -> signals held stable throughout, sequence and result unchanged.
REQ-026 rst_n_i pulsed low during data-phase WAIT -> outputs reset values at once, no rsp_valid_o, next request starts with CSR=0xC0.

Source files
------------

// File: rtl/i2c_cmd_sequencer.sv
// Turns single-byte I2C read/write requests into the Wishbone register
// sequence (CSR/DPR/CMDR) of an I2C master core, waiting on its interrupt.
module i2c_cmd_sequencer #(
  parameter int WB_ADDR_WIDTH = 2,
  parameter int WB_DATA_WIDTH = 8,
  parameter int IRQ_TIMEOUT   = 65535
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic                     req_rnw_i,
  input  logic [3:0]               req_bus_i,
  input  logic [6:0]               req_addr_i,
  input  logic [7:0]               req_data_i,
  output logic                     rsp_valid_o,
  output logic [7:0]               rsp_data_o,
  output logic [1:0]               rsp_status_o,
  output logic                     cyc_o,
  output logic                     stb_o,
  output logic                     we_o,
  output logic [WB_ADDR_WIDTH-1:0] adr_o,
  output logic [WB_DATA_WIDTH-1:0] dat_o,
  input  logic [WB_DATA_WIDTH-1:0] dat_i,
  input  logic                     ack_i,
  input  logic                     irq_i
);

  localparam int CNT_W = $clog2(IRQ_TIMEOUT + 1);

  localparam logic [1:0] REG_CSR  = 2'd0;
  localparam logic [1:0] REG_DPR  = 2'd1;
  localparam logic [1:0] REG_CMDR = 2'd2;

  localparam logic [1:0] STAT_OK      = 2'b00;
  localparam logic [1:0] STAT_NAK     = 2'b01;
  localparam logic [1:0] STAT_ERR     = 2'b10;
  localparam logic [1:0] STAT_TIMEOUT = 2'b11;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CSR,
    ST_DPR_BUS,
    ST_CMD_BUS,
    ST_CMD_START,
    ST_DPR_ADDR,
    ST_CMD_ADDR,
    ST_DPR_DATA,
    ST_CMD_DATA,
    ST_CMD_RD,
    ST_DPR_RD,
    ST_CMD_STOP,
    ST_WAIT,
    ST_WAIT_RD,
    ST_RESPOND
  } state_t;

  state_t           state_q, state_d;
  state_t           wait_next_q, wait_next_d;
  logic             gap_q, gap_d;
  logic             enabled_q, enabled_d;
  logic             ready_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       rd_byte_q, rd_byte_d;
  logic [1:0]       status_q, status_d;
  logic [7:0]       rsp_data_q;
  logic [1:0]       rsp_status_q;

  logic             rnw_q;
  logic [3:0]       bus_q;
  logic [6:0]       addr_q;
  logic [7:0]       data_q;

  logic             accept;
  logic             access;
  logic             active;
  logic             wb_done;
  logic             wb_we;
  logic [1:0]       wb_reg;
  logic [7:0]       wb_byte;
  logic [7:0]       rd_in;

  assign accept  = req_valid_i && ready_q && (state_q == ST_IDLE);
  assign active  = access && !gap_q;
  assign wb_done = active && ack_i;
  assign rd_in   = 8'(dat_i);

  // Each access state owns one Wishbone register access; gap_q forces the
  // one idle cycle between back-to-back accesses.
  always_comb begin
    access  = 1'b1;
    wb_we   = 1'b1;
    wb_reg  = REG_CSR;
    wb_byte = 8'h00;
    unique case (state_q)
      ST_CSR:       wb_byte = 8'hC0;
      ST_DPR_BUS:   begin wb_reg = REG_DPR;  wb_byte = {4'h0, bus_q};   end
      ST_CMD_BUS:   begin wb_reg = REG_CMDR; wb_byte = 8'h06;           end
      ST_CMD_START: begin wb_reg = REG_CMDR; wb_byte = 8'h04;           end
      ST_DPR_ADDR:  begin wb_reg = REG_DPR;  wb_byte = {addr_q, rnw_q}; end
      ST_CMD_ADDR:  begin wb_reg = REG_CMDR; wb_byte = 8'h01;           end
      ST_DPR_DATA:  begin wb_reg = REG_DPR;  wb_byte = data_q;          end
      ST_CMD_DATA:  begin wb_reg = REG_CMDR; wb_byte = 8'h01;           end
      ST_CMD_RD:    begin wb_reg = REG_CMDR; wb_byte = 8'h03;           end
      ST_CMD_STOP:  begin wb_reg = REG_CMDR; wb_byte = 8'h05;           end
      ST_DPR_RD:    begin wb_reg = REG_DPR;  wb_we = 1'b0;              end
      ST_WAIT_RD:   begin wb_reg = REG_CMDR; wb_we = 1'b0;              end
      default:      begin access = 1'b0;     wb_we = 1'b0;              end
    endcase
  end

  assign cyc_o = active;
  assign stb_o = active;
  assign we_o  = active && wb_we;
  assign adr_o = active ? WB_ADDR_WIDTH'(wb_reg) : '0;
  assign dat_o = active ? WB_DATA_WIDTH'(wb_byte) : '0;

  always_comb begin
    state_d     = state_q;
    wait_next_d = wait_next_q;
    gap_d       = wb_done;
    enabled_d   = enabled_q;
    cnt_d       = cnt_q;
    rd_byte_d   = rd_byte_q;
    status_d    = status_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          status_d  = STAT_OK;
          rd_byte_d = 8'h00;
          state_d   = enabled_q ? ST_DPR_BUS : ST_CSR;
        end
      end
      ST_CSR: begin
        if (wb_done) begin
          enabled_d = 1'b1;
          state_d   = ST_DPR_BUS;
        end
      end
      ST_DPR_BUS:  if (wb_done) state_d = ST_CMD_BUS;
      ST_DPR_ADDR: if (wb_done) state_d = ST_CMD_ADDR;
      ST_DPR_DATA: if (wb_done) state_d = ST_CMD_DATA;
      ST_CMD_BUS, ST_CMD_START, ST_CMD_ADDR, ST_CMD_DATA, ST_CMD_RD, ST_CMD_STOP: begin
        if (wb_done) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
          unique case (state_q)
            ST_CMD_BUS:   wait_next_d = ST_CMD_START;
            ST_CMD_START: wait_next_d = ST_DPR_ADDR;
            ST_CMD_ADDR:  wait_next_d = rnw_q ? ST_CMD_RD : ST_DPR_DATA;
            ST_CMD_DATA:  wait_next_d = ST_CMD_STOP;
            ST_CMD_RD:    wait_next_d = ST_DPR_RD;
            default:      wait_next_d = ST_RESPOND;
          endcase
        end
      end
      ST_DPR_RD: begin
        if (wb_done) begin
          rd_byte_d = rd_in;
          state_d   = ST_CMD_STOP;
        end
      end
      // An interrupt that arrives on the last counted cycle still wins.
      ST_WAIT: begin
        if (irq_i) begin
          state_d = ST_WAIT_RD;
        end else if (cnt_q == CNT_W'(IRQ_TIMEOUT - 1)) begin
          state_d = ST_RESPOND;
          if (status_q == STAT_OK) status_d = STAT_TIMEOUT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      // Only the first fault is kept; a NAK still closes the bus with a stop.
      ST_WAIT_RD: begin
        if (wb_done) begin
          if (rd_in[5] || rd_in[4]) begin
            state_d = ST_RESPOND;
            if (status_q == STAT_OK) status_d = STAT_ERR;
          end else if (rd_in[6]) begin
            if (status_q == STAT_OK) status_d = STAT_NAK;
            state_d = (wait_next_q == ST_RESPOND) ? ST_RESPOND : ST_CMD_STOP;
          end else begin
            state_d = wait_next_q;
          end
        end
      end
      ST_RESPOND: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= ST_IDLE;
      wait_next_q  <= ST_IDLE;
      gap_q        <= 1'b0;
      enabled_q    <= 1'b0;
      ready_q      <= 1'b0;
      cnt_q        <= '0;
      rd_byte_q    <= 8'h00;
      status_q     <= STAT_OK;
      rsp_data_q   <= 8'h00;
      rsp_status_q <= STAT_OK;
    end else begin
      state_q     <= state_d;
      wait_next_q <= wait_next_d;
      gap_q       <= gap_d;
      enabled_q   <= enabled_d;
      ready_q     <= (state_d == ST_IDLE);
      cnt_q       <= cnt_d;
      rd_byte_q   <= rd_byte_d;
      status_q    <= status_d;
      if (state_d == ST_RESPOND) begin
        rsp_data_q   <= rnw_q ? rd_byte_d : 8'h00;
        rsp_status_q <= status_d;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rnw_q  <= 1'b0;
      bus_q  <= 4'h0;
      addr_q <= 7'h00;
      data_q <= 8'h00;
    end else if (accept) begin
      rnw_q  <= req_rnw_i;
      bus_q  <= req_bus_i;
      addr_q <= req_addr_i;
      data_q <= req_data_i;
    end
  end

  assign req_ready_o  = ready_q;
  assign rsp_valid_o  = (state_q == ST_RESPOND);
  assign rsp_data_o   = rsp_data_q;
  assign rsp_status_o = rsp_status_q;

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Bench for i2c_cmd_sequencer: a reactive Wishbone/I2C-core model plus
// queues of expected register accesses and responses.
module tb_i2c_cmd_sequencer;

  localparam int IRQ_TO = 16;
  localparam int SC_OK  = 0;
  localparam int SC_NAK = 1;
  localparam int SC_AL  = 2;
  localparam int SC_TO  = 3;
  localparam int SC_RST = 4;

  logic       clk_i;
  logic       rst_n_i;
  logic       req_valid_i;
  logic       req_ready_o;
  logic       req_rnw_i;
  logic [3:0] req_bus_i;
  logic [6:0] req_addr_i;
  logic [7:0] req_data_i;
  logic       rsp_valid_o;
  logic [7:0] rsp_data_o;
  logic [1:0] rsp_status_o;
  logic       cyc_o, stb_o, we_o;
  logic [1:0] adr_o;
  logic [7:0] dat_o;
  logic [7:0] dat_i;
  logic       ack_i;
  logic       irq_i;

  int checks = 0;
  int errors = 0;
  int cyc_count = 0;
  int ack_delay = 0;
  int irq_limit = 1000000;
  int cmdr_writes = 0;
  int last_ack_cycle = 0;
  int rsp_cycle = 0;
  logic [7:0] rd_value = 8'h00;

  logic [10:0] exp_wb[$];
  logic [9:0]  exp_rsp[$];
  logic [7:0]  stat_q[$];

  i2c_cmd_sequencer #(
    .WB_ADDR_WIDTH(2),
    .WB_DATA_WIDTH(8),
    .IRQ_TIMEOUT(IRQ_TO)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_rnw_i(req_rnw_i), .req_bus_i(req_bus_i),
    .req_addr_i(req_addr_i), .req_data_i(req_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_status_o(rsp_status_o),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
    .dat_i(dat_i), .ack_i(ack_i), .irq_i(irq_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc_count <= cyc_count + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [10:0] wr(input logic [1:0] r, input logic [7:0] b);
    return {1'b1, r, b};
  endfunction

  function automatic logic [10:0] rdr(input logic [1:0] r);
    return {1'b0, r, 8'h00};
  endfunction

  // Expected register traffic and response for one request.
  task automatic pushExpected(input bit rnw, input logic [3:0] bus, input logic [6:0] addr,
                              input logic [7:0] data, input bit csr, input int sc,
                              input logic [7:0] rdv);
    if (csr) exp_wb.push_back(wr(2'd0, 8'hC0));
    exp_wb.push_back(wr(2'd1, {4'h0, bus}));
    exp_wb.push_back(wr(2'd2, 8'h06));
    if (sc == SC_TO) begin
      exp_rsp.push_back({8'h00, 2'b11});
      return;
    end
    exp_wb.push_back(rdr(2'd2));
    exp_wb.push_back(wr(2'd2, 8'h04));
    exp_wb.push_back(rdr(2'd2));
    if (sc == SC_AL) begin
      exp_rsp.push_back({8'h00, 2'b10});
      return;
    end
    exp_wb.push_back(wr(2'd1, {addr, rnw}));
    exp_wb.push_back(wr(2'd2, 8'h01));
    exp_wb.push_back(rdr(2'd2));
    if (sc == SC_RST) begin
      exp_wb.push_back(wr(2'd1, data));
      exp_wb.push_back(wr(2'd2, 8'h01));
      return;
    end
    if (sc != SC_NAK) begin
      if (rnw) begin
        exp_wb.push_back(wr(2'd2, 8'h03));
        exp_wb.push_back(rdr(2'd2));
        exp_wb.push_back(rdr(2'd1));
      end else begin
        exp_wb.push_back(wr(2'd1, data));
        exp_wb.push_back(wr(2'd2, 8'h01));
        exp_wb.push_back(rdr(2'd2));
      end
    end
    exp_wb.push_back(wr(2'd2, 8'h05));
    exp_wb.push_back(rdr(2'd2));
    exp_rsp.push_back({(rnw && sc == SC_OK) ? rdv : 8'h00, (sc == SC_NAK) ? 2'b01 : 2'b00});
  endtask

  task automatic applyStimulus(input bit rnw, input logic [3:0] bus, input logic [6:0] addr,
                               input logic [7:0] data, input bit csr, input int sc,
                               input logic [7:0] rdv, input bit hold);
    int n;
    rd_value = rdv;
    pushExpected(rnw, bus, addr, data, csr, sc, rdv);
    @(negedge clk_i);
    req_rnw_i   = rnw;
    req_bus_i   = bus;
    req_addr_i  = addr;
    req_data_i  = data;
    req_valid_i = 1'b1;
    n = 0;
    while (!req_ready_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    checkOutput("req_ready", req_ready_o, 1);
    @(negedge clk_i);
    checkOutput("ready_drop", req_ready_o, 0);
    if (hold) begin
      req_rnw_i  = ~rnw;
      req_bus_i  = 4'hF;
      req_addr_i = 7'h7F;
      req_data_i = 8'hEE;
      repeat (8) @(negedge clk_i);
    end
    req_valid_i = 1'b0;
    if (sc != SC_RST) begin
      n = 0;
      while ((exp_wb.size() != 0 || exp_rsp.size() != 0) && n < 3000) begin
        @(negedge clk_i);
        n++;
      end
      checkOutput("drain", exp_wb.size() + exp_rsp.size(), 0);
      if (sc == SC_TO) checkOutput("to_latency", rsp_cycle - last_ack_cycle, IRQ_TO + 1);
      repeat (4) @(negedge clk_i);
    end
  endtask

  // Wishbone slave and I2C core model, driven on the falling edge.
  initial begin
    int wait_cnt;
    int irq_cnt;
    bit started;
    bit stable;
    logic [10:0] first_ctl;
    logic [10:0] obs;
    ack_i = 1'b0;
    irq_i = 1'b0;
    dat_i = 8'h00;
    wait_cnt = 0;
    irq_cnt = 0;
    started = 1'b0;
    stable = 1'b1;
    first_ctl = '0;
    forever begin
      @(negedge clk_i);
      if (!rst_n_i) begin
        ack_i = 1'b0;
        irq_i = 1'b0;
        irq_cnt = 0;
        started = 1'b0;
        continue;
      end
      if (irq_cnt > 0) begin
        irq_cnt--;
        if (irq_cnt == 0) irq_i = 1'b1;
      end
      if (ack_i) begin
        ack_i = 1'b0;
        started = 1'b0;
        checkOutput("wb_gap", cyc_o, 0);
      end else if (cyc_o && stb_o) begin
        if (!started) begin
          started = 1'b1;
          stable = 1'b1;
          wait_cnt = 0;
          first_ctl = {we_o, adr_o, dat_o};
        end else if ({we_o, adr_o, dat_o} !== first_ctl) begin
          stable = 1'b0;
        end
        if (wait_cnt < ack_delay) begin
          wait_cnt++;
        end else begin
          ack_i = 1'b1;
          last_ack_cycle = cyc_count;
          obs = {we_o, adr_o, we_o ? dat_o : 8'h00};
          checkOutput("wb_stable", stable, 1);
          if (exp_wb.size() == 0) checkOutput("wb_unexpected", cyc_o, 0);
          else checkOutput("wb_access", obs, exp_wb.pop_front());
          if (!we_o) begin
            if (adr_o == 2'd2) begin
              dat_i = (stat_q.size() != 0) ? stat_q.pop_front() : 8'h80;
              irq_i = 1'b0;
            end else begin
              dat_i = rd_value;
            end
          end else if (adr_o == 2'd2) begin
            cmdr_writes++;
            irq_cnt = (cmdr_writes <= irq_limit) ? 3 : 0;
          end
        end
      end
    end
  end

  // Response scoreboard.
  initial begin
    bit prev_valid;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk_i);
      if (prev_valid) checkOutput("rsp_pulse", rsp_valid_o, 0);
      prev_valid = rsp_valid_o;
      if (rsp_valid_o) begin
        rsp_cycle = cyc_count;
        if (exp_rsp.size() == 0) checkOutput("rsp_unexpected", rsp_valid_o, 0);
        else checkOutput("rsp", {rsp_data_o, rsp_status_o}, exp_rsp.pop_front());
      end
    end
  end

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_cyc"}, cyc_o, 0);
    checkOutput({tag, "_stb"}, stb_o, 0);
    checkOutput({tag, "_we"}, we_o, 0);
    checkOutput({tag, "_adr"}, adr_o, 0);
    checkOutput({tag, "_dat"}, dat_o, 0);
    checkOutput({tag, "_ready"}, req_ready_o, 0);
    checkOutput({tag, "_rsp_valid"}, rsp_valid_o, 0);
    checkOutput({tag, "_rsp_data"}, rsp_data_o, 0);
    checkOutput({tag, "_rsp_status"}, rsp_status_o, 0);
  endtask

  initial begin
    int n;
    int base;
    rst_n_i     = 1'b0;
    req_valid_i = 1'b0;
    req_rnw_i   = 1'b0;
    req_bus_i   = 4'h0;
    req_addr_i  = 7'h00;
    req_data_i  = 8'h00;
    repeat (3) @(negedge clk_i);
    checkResetOutputs("reset");
    rst_n_i = 1'b1;
    @(negedge clk_i);
    checkOutput("ready_after_reset", req_ready_o, 1);

    $display("[TB] first write with enable");
    applyStimulus(1'b0, 4'd0, 7'h22, 8'h5A, 1'b1, SC_OK, 8'h00, 1'b0);

    $display("[TB] read, request held while busy");
    applyStimulus(1'b1, 4'd1, 7'h22, 8'h00, 1'b0, SC_OK, 8'hA5, 1'b1);

    $display("[TB] address NAK");
    stat_q.push_back(8'h80);
    stat_q.push_back(8'h80);
    stat_q.push_back(8'h40);
    applyStimulus(1'b0, 4'd2, 7'h10, 8'h33, 1'b0, SC_NAK, 8'h00, 1'b0);

    $display("[TB] arbitration lost on start");
    stat_q.push_back(8'h80);
    stat_q.push_back(8'h20);
    applyStimulus(1'b1, 4'd5, 7'h31, 8'h00, 1'b0, SC_AL, 8'h77, 1'b0);

    $display("[TB] irq timeout");
    irq_limit = cmdr_writes;
    applyStimulus(1'b0, 4'd3, 7'h11, 8'h99, 1'b0, SC_TO, 8'h00, 1'b0);
    irq_limit = 1000000;

    $display("[TB] slow ack read");
    ack_delay = 5;
    applyStimulus(1'b1, 4'd1, 7'h22, 8'h00, 1'b0, SC_OK, 8'h3C, 1'b0);
    ack_delay = 0;

    $display("[TB] reset during data-phase wait");
    base = cmdr_writes;
    irq_limit = base + 3;
    applyStimulus(1'b0, 4'd4, 7'h50, 8'hC3, 1'b0, SC_RST, 8'h00, 1'b0);
    n = 0;
    while (cmdr_writes < base + 4 && n < 2000) begin
      @(negedge clk_i);
      n++;
    end
    checkOutput("rst_reach_wait", cmdr_writes - base, 4);
    repeat (3) @(negedge clk_i);
    #2 rst_n_i = 1'b0;
    #1 checkResetOutputs("midreset");
    checkOutput("rst_drain", exp_wb.size(), 0);
    repeat (2) @(negedge clk_i);
    exp_wb.delete();
    irq_limit = 1000000;
    rst_n_i = 1'b1;
    @(negedge clk_i);
    checkOutput("ready_after_midreset", req_ready_o, 1);

    $display("[TB] write after reset re-enables");
    applyStimulus(1'b0, 4'd6, 7'h0F, 8'h81, 1'b1, SC_OK, 8'h00, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
